// File: rtl/rtc_arbiter.sv
// Three-requester round-robin arbiter with lock override in front of an RTC serial engine.
// Each grant runs one engine transaction, ending in an ack, or in an err if the engine never answers.
module rtc_arbiter #(
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [2:0]  req,
    input  logic [23:0] req_addr,
    input  logic [23:0] req_wdata,
    input  logic [2:0]  lock,
    output logic [2:0]  ack,
    output logic [2:0]  err,
    output logic [7:0]  rdata,
    output logic [2:0]  gnt,
    output logic [7:0]  rtc_addr,
    output logic [7:0]  rtc_w,
    output logic        rtc_ena,
    input  logic [7:0]  rtc_r,
    input  logic        rtc_done
);

    // state | meaning
    // IDLE  | no owner; arbitrate when any req is high
    // BUSY  | engine transaction in flight, rtc_ena high, timeout counter running
    // DONE  | one-cycle ack/err pulse, gnt still held
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [15:0] TC = 16'(TIMEOUT - 1);

    state_t      state;
    logic [1:0]  last_own;
    logic [15:0] cnt;
    logic [1:0]  c0, c1, win;
    logic [7:0]  sel_addr, sel_wdata;

    // Round-robin search order is c0, c1, then the last owner itself.
    always_comb begin
        c0  = (last_own == 2'd2) ? 2'd0 : last_own + 2'd1;
        c1  = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;
        win = last_own;
        if (lock[last_own] && req[last_own])
            win = last_own;
        else if (req[c0])
            win = c0;
        else if (req[c1])
            win = c1;
    end

    always_comb begin
        case (win)
            2'd0:    begin sel_addr = req_addr[7:0];   sel_wdata = req_wdata[7:0];   end
            2'd1:    begin sel_addr = req_addr[15:8];  sel_wdata = req_wdata[15:8];  end
            default: begin sel_addr = req_addr[23:16]; sel_wdata = req_wdata[23:16]; end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= IDLE;
            last_own <= 2'd2;
            cnt      <= 16'd0;
            ack      <= 3'b000;
            err      <= 3'b000;
            gnt      <= 3'b000;
            rdata    <= 8'h00;
            rtc_addr <= 8'h00;
            rtc_w    <= 8'h00;
            rtc_ena  <= 1'b0;
        end else begin
            ack <= 3'b000;
            err <= 3'b000;
            case (state)
                IDLE: begin
                    if (|req) begin
                        last_own <= win;
                        gnt      <= 3'b001 << win;
                        rtc_addr <= sel_addr;
                        rtc_w    <= sel_wdata;
                        rtc_ena  <= 1'b1;
                        cnt      <= 16'd0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // A completion in the terminal-count cycle still counts as success.
                    if (rtc_done || cnt == TC) begin
                        if (rtc_done) begin
                            rdata <= rtc_r;
                            ack   <= gnt;
                        end else begin
                            err   <= gnt;
                        end
                        rtc_ena  <= 1'b0;
                        rtc_addr <= 8'h00;
                        rtc_w    <= 8'h00;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE: begin
                    gnt   <= 3'b000;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_arbiter.sv
// Directed bench for rtc_arbiter (TIMEOUT=16): inputs driven and outputs sampled on the falling edge.
module tb_rtc_arbiter;

    logic        clk = 1'b0;
    logic        clrn;
    logic [2:0]  req, lock, ack, err, gnt;
    logic [23:0] req_addr, req_wdata;
    logic [7:0]  rdata, rtc_addr, rtc_w, rtc_r;
    logic        rtc_ena, rtc_done;

    int n_chk  = 0;
    int n_fail = 0;
    int waited;
    int n_hi;

    rtc_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .clrn(clrn), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
        .lock(lock), .ack(ack), .err(err), .rdata(rdata), .gnt(gnt),
        .rtc_addr(rtc_addr), .rtc_w(rtc_w), .rtc_ena(rtc_ena), .rtc_r(rtc_r), .rtc_done(rtc_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b0; req = 3'b000; lock = 3'b000; rtc_done = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
    endtask

    // Waits for the grant, holds the engine for n_busy cycles, then completes with rv.
    task automatic serve(input string tag, input logic [2:0] exp_gnt, input logic [7:0] exp_a,
                         input logic [7:0] exp_w, input int n_busy, input logic [7:0] rv,
                         input bit disturb, output int wt);
        wt = 0;
        @(negedge clk);
        while (!rtc_ena && wt < 10) begin
            @(negedge clk);
            wt++;
        end
        chk({tag, "_ena"}, rtc_ena, 1);
        chk({tag, "_gnt"}, gnt, exp_gnt);
        for (int k = 1; k <= n_busy; k++) begin
            if (k > 1) @(negedge clk);
            chk({tag, "_busy_ena"}, rtc_ena, 1);
            chk({tag, "_addr"}, rtc_addr, exp_a);
            chk({tag, "_w"}, rtc_w, exp_w);
            if (disturb && k == 2) begin
                req = 3'b000; req_addr = ~req_addr; req_wdata = ~req_wdata;
            end
            if (k == n_busy) begin
                rtc_done = 1'b1; rtc_r = rv;
            end
        end
        @(negedge clk);
        rtc_done = 1'b0;
        chk({tag, "_ack"}, ack, exp_gnt);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_done_ena"}, rtc_ena, 0);
        chk({tag, "_done_gnt"}, gnt, exp_gnt);
        chk({tag, "_rdata"}, rdata, rv);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn = 1'b0; req = 3'b000; lock = 3'b000; req_addr = 24'h0; req_wdata = 24'h0;
        rtc_r = 8'h00; rtc_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_ena", rtc_ena, 0);
        chk("rst_addr", rtc_addr, 0);
        chk("rst_w", rtc_w, 0);
        chk("rst_rdata", rdata, 0);
        clrn = 1'b1;

        // Single read; request dropped and inputs scrambled mid-transaction.
        @(negedge clk);
        req = 3'b001; req_addr = 24'h000081; req_wdata = 24'h000000;
        serve("rd", 3'b001, 8'h81, 8'h00, 5, 8'h80, 1'b1, waited);
        chk("rd_latency", waited, 0);
        req = 3'b000;
        @(negedge clk);
        chk("rd_idle_gnt", gnt, 0);
        chk("rd_idle_addr", rtc_addr, 0);
        chk("rd_idle_ack", ack, 0);
        chk("rd_hold_rdata", rdata, 8'h80);

        // Contention: order 0,1,2,0 with two enable-low cycles between transactions.
        do_reset();
        req = 3'b111; req_addr = 24'h322110; req_wdata = 24'h625140;
        serve("rr0", 3'b001, 8'h10, 8'h40, 2, 8'h01, 1'b0, waited);
        serve("rr1", 3'b010, 8'h21, 8'h51, 3, 8'h02, 1'b0, waited);
        chk("rr1_gap", waited + 1, 2);
        serve("rr2", 3'b100, 8'h32, 8'h62, 1, 8'h03, 1'b0, waited);
        chk("rr2_gap", waited + 1, 2);
        serve("rr3", 3'b001, 8'h10, 8'h40, 2, 8'h04, 1'b0, waited);
        chk("rr3_gap", waited + 1, 2);

        // Lock: requester 0 keeps ownership for three writes, then requester 1.
        do_reset();
        req = 3'b011; lock = 3'b001; req_addr = 24'h00a18e; req_wdata = 24'h00b100;
        serve("lk0", 3'b001, 8'h8e, 8'h00, 2, 8'h11, 1'b0, waited);
        req_addr = 24'h00a180; req_wdata = 24'h00b112;
        serve("lk1", 3'b001, 8'h80, 8'h12, 2, 8'h22, 1'b0, waited);
        req_addr = 24'h00a182; req_wdata = 24'h00b134;
        serve("lk2", 3'b001, 8'h82, 8'h34, 2, 8'h33, 1'b0, waited);
        lock = 3'b000;
        serve("lk3", 3'b010, 8'ha1, 8'hb1, 2, 8'h44, 1'b0, waited);
        req = 3'b000;

        // Timeout: a read from requester 1 sets rdata, then a transaction with no rtc_done.
        do_reset();
        req = 3'b010; req_addr = 24'h005a00; req_wdata = 24'h006600;
        serve("to_rd", 3'b010, 8'h5a, 8'h66, 3, 8'h3c, 1'b0, waited);
        waited = 0;
        @(negedge clk);
        while (!rtc_ena && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        n_hi = 0;
        while (rtc_ena && n_hi < 40) begin
            n_hi++;
            @(negedge clk);
        end
        chk("to_ena_cycles", n_hi, 16);
        chk("to_err", err, 3'b010);
        chk("to_ack", ack, 0);
        chk("to_rdata", rdata, 8'h3c);
        chk("to_gnt", gnt, 3'b010);
        req = 3'b000;
        @(negedge clk);
        chk("to_err_pulse", err, 0);
        chk("to_idle_gnt", gnt, 0);

        // Completion in the final timeout cycle wins over the timeout.
        req = 3'b100; req_addr = 24'hc30000; req_wdata = 24'h990000;
        serve("dto", 3'b100, 8'hc3, 8'h99, 16, 8'ha5, 1'b0, waited);
        req = 3'b000;

        // rtc_done while idle is ignored.
        @(negedge clk);
        rtc_done = 1'b1; rtc_r = 8'hff;
        @(negedge clk);
        rtc_done = 1'b0;
        chk("idle_done_rdata", rdata, 8'ha5);
        chk("idle_done_ack", ack, 0);
        chk("idle_done_ena", rtc_ena, 0);

        // Reset in the third BUSY cycle abandons the transaction; arbitration restarts at 0.
        do_reset();
        req = 3'b010; req_addr = 24'h007700; req_wdata = 24'h000000;
        repeat (3) @(negedge clk);
        chk("mr_busy", rtc_ena, 1);
        clrn = 1'b0;
        #1;
        chk("mr_ena", rtc_ena, 0);
        chk("mr_gnt", gnt, 0);
        req = 3'b111; req_addr = 24'h3377a0; req_wdata = 24'h0000b0;
        @(negedge clk);
        chk("mr_ack", ack, 0);
        chk("mr_err", err, 0);
        clrn = 1'b1;
        serve("mr_next", 3'b001, 8'ha0, 8'hb0, 2, 8'h5e, 1'b0, waited);
        req = 3'b000;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
